// File: rtl/pixel_framebuffer_vga.sv
// pixel_framebuffer_vga: plot/X/Y/color write port into a FB_W x FB_H x 3 framebuffer,
// scanned out as VGA with 2x2 pixel replication, plus a full-screen clear sweep.
module pixel_framebuffer_vga #(
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int COLOR_W = 3,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               plot,
    input  logic [8:0]         X,
    input  logic [7:0]         Y,
    input  logic [COLOR_W-1:0] color,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               dropped,
    output logic               vga_r,
    output logic               vga_g,
    output logic               vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n
);
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int AW      = $clog2(FB_SIZE);
    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOT);
    localparam int VW      = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [8:0]    X_LIM   = 9'(FB_W);
    localparam logic [7:0]    Y_LIM   = 8'(FB_H);
    localparam logic [AW-1:0] ADDR_LAST = AW'(FB_SIZE - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

    // Framebuffer storage (not reset; contents survive reset)
    logic [COLOR_W-1:0] mem [0:FB_SIZE-1];

    // Clear sweep state
    clr_state_t    state_reg;
    logic [AW-1:0] clear_addr_reg;
    logic          clear_busy_reg;
    logic          clear_start;

    // Write pipeline: S0 sample, S1 address, write on the following edge
    logic               s0_valid_reg;
    logic [8:0]         s0_x_reg;
    logic [7:0]         s0_y_reg;
    logic [COLOR_W-1:0] s0_color_reg;
    logic               s1_valid_reg;
    logic [AW-1:0]      s1_addr_reg;
    logic [COLOR_W-1:0] s1_color_reg;
    logic               dropped_reg;
    logic               in_range;
    logic               plot_ok;

    // Shared write port
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [COLOR_W-1:0] wr_data;

    // Scan side
    logic               pix_phase_reg;
    logic [HW-1:0]      hcount_reg;
    logic [VW-1:0]      vcount_reg;
    logic [AW-1:0]      rd_addr_reg;
    logic [COLOR_W-1:0] rd_data_reg;
    logic               hs_reg;
    logic               vs_reg;
    logic               blank_n_reg;
    logic               visible;
    logic [2:0]         rgb_out;

    assign clear_start = (state_reg == ST_IDLE) && clear_req;
    assign in_range    = (X < X_LIM) && (Y < Y_LIM);
    // A plot landing with clear_req or during a sweep would be wiped anyway, so it is refused.
    assign plot_ok     = plot && in_range && !clear_busy_reg && !clear_req;
    assign visible     = (hcount_reg < H_VIS_C) && (vcount_reg < V_VIS_C);

    // Clear FSM: one zero write per cycle over the whole buffer, restart requests ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            clear_addr_reg <= '0;
            clear_busy_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_reg      <= ST_CLEAR;
                        clear_addr_reg <= '0;
                        clear_busy_reg <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clear_addr_reg == ADDR_LAST) begin
                        state_reg      <= ST_IDLE;
                        clear_busy_reg <= 1'b0;
                    end else begin
                        clear_addr_reg <= clear_addr_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Plot pipeline; anything in flight when a sweep starts is discarded
    always_ff @(posedge clock) begin
        if (reset) begin
            s0_valid_reg <= 1'b0;
            s0_x_reg     <= '0;
            s0_y_reg     <= '0;
            s0_color_reg <= '0;
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s1_color_reg <= '0;
            dropped_reg  <= 1'b0;
        end else begin
            s0_valid_reg <= plot_ok;
            s0_x_reg     <= X;
            s0_y_reg     <= Y;
            s0_color_reg <= color;
            dropped_reg  <= plot && !plot_ok;
            s1_valid_reg <= s0_valid_reg && !clear_start && !clear_busy_reg;
            // For FB_W=320 this constant multiply reduces to (Y<<8)+(Y<<6)
            s1_addr_reg  <= AW'(s0_y_reg) * AW'(FB_W) + AW'(s0_x_reg);
            s1_color_reg <= s0_color_reg;
        end
    end

    // Write-port arbitration: the clear sweep always wins
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_addr_reg;
        wr_data = s1_color_reg;
        if (state_reg == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clear_addr_reg;
            wr_data = '0;
        end else if (s1_valid_reg && !clear_start) begin
            wr_en   = 1'b1;
        end
    end

    // RAM write port
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // RAM read port, registered; same-address write in the same cycle returns old data
    always_ff @(posedge clock) begin
        rd_data_reg <= mem[rd_addr_reg];
    end

    // Pixel tick phase and raster counters
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_phase_reg <= 1'b0;
            hcount_reg    <= '0;
            vcount_reg    <= '0;
        end else begin
            pix_phase_reg <= !pix_phase_reg;
            if (pix_phase_reg) begin
                if (hcount_reg == H_LAST) begin
                    hcount_reg <= '0;
                    vcount_reg <= (vcount_reg == V_LAST) ? '0 : vcount_reg + 1'b1;
                end else begin
                    hcount_reg <= hcount_reg + 1'b1;
                end
            end
        end
    end

    // Read address from the counters; off-screen positions park at address 0
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr_reg <= '0;
        end else begin
            rd_addr_reg <= visible ? AW'(vcount_reg >> 1) * AW'(FB_W) + AW'(hcount_reg >> 1) : '0;
        end
    end

    // Sync and blank, delayed one pixel tick to line up with the RAM data
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            blank_n_reg <= 1'b0;
        end else if (pix_phase_reg) begin
            hs_reg      <= !((hcount_reg >= HS_BEG) && (hcount_reg < HS_END));
            vs_reg      <= !((vcount_reg >= VS_BEG) && (vcount_reg < VS_END));
            blank_n_reg <= visible;
        end
    end

    // Color gating: bit 2 -> R, bit 1 -> G, bit 0 -> B
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
            assign rgb_out[gi] = blank_n_reg & rd_data_reg[gi];
        end
    endgenerate

    assign vga_r       = rgb_out[2];
    assign vga_g       = rgb_out[1];
    assign vga_b       = rgb_out[0];
    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;
    assign vga_blank_n = blank_n_reg;
    assign clear_busy  = clear_busy_reg;
    assign dropped     = dropped_reg;

endmodule

// File: tb/tb_pixel_framebuffer_vga.sv
// Scoreboard bench for pixel_framebuffer_vga on a reduced 16x12 geometry (32x24 visible).
module tb_pixel_framebuffer_vga;
    localparam int FB_W = 16, FB_H = 12;
    localparam int H_VIS = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_VIS = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int HT = 48, VT = 30;
    localparam int FRAME_CLK = 2 * HT * VT;   // 2880

    logic       clk = 1'b0;
    logic       reset, plot, clear_req;
    logic [8:0] X;
    logic [7:0] Y;
    logic [2:0] color;
    logic       clear_busy, dropped, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n;

    pixel_framebuffer_vga #(
        .FB_W(FB_W), .FB_H(FB_H), .COLOR_W(3),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clock(clk), .reset(reset), .plot(plot), .X(X), .Y(Y), .color(color),
        .clear_req(clear_req), .clear_busy(clear_busy), .dropped(dropped),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
    );

    always #5 clk = ~clk;

    typedef struct { int h; int v; int min_cyc; int rgb; int blank; int hs; int vs; } probe_t;
    typedef struct { int v; int min_cyc; int hs_lo; int bl_hi; int vs_lo; } line_t;

    probe_t probe_q[$];
    line_t  line_q[$];
    int     drop_q[$];
    int     busy_q[$];
    int     frame_q[$];

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;
    logic rst_q = 1'b0;

    // monitor state
    int n = 0, hs_cnt = 0, bl_cnt = 0, vs_cnt = 0, busy_len = 0, last_fall = -1;
    int k, h, v;
    logic vs_prev = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected sync/blank come from the nominal timing of the reduced geometry.
    function automatic void push_probe(input int ph, input int pv, input int rgb, input int mc);
        probe_t p;
        p.h = ph; p.v = pv; p.min_cyc = mc;
        p.blank = (ph < H_VIS && pv < V_VIS) ? 1 : 0;
        p.rgb   = p.blank ? rgb : 0;
        p.hs    = (ph >= 36 && ph < 44) ? 0 : 1;
        p.vs    = (pv >= 26 && pv < 28) ? 0 : 1;
        probe_q.push_back(p);
    endfunction

    function automatic void push_line(input int lv, input int mc, input int hl, input int bh, input int vl);
        line_t l;
        l.v = lv; l.min_cyc = mc; l.hs_lo = hl; l.bl_hi = bh; l.vs_lo = vl;
        line_q.push_back(l);
    endfunction

    // cycle counter and registered view of reset
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_q = reset;
        end
    end

    // Monitor: pops expectations whenever the DUT presents the corresponding output
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                chk("rst_hs", int'(vga_hs), 1);
                chk("rst_vs", int'(vga_vs), 1);
                chk("rst_blank_n", int'(vga_blank_n), 0);
                chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
                chk("rst_clear_busy", int'(clear_busy), 0);
                chk("rst_dropped", int'(dropped), 0);
                n = 0; hs_cnt = 0; bl_cnt = 0; vs_cnt = 0; busy_len = 0;
                last_fall = -1; vs_prev = 1'b1;
            end else begin
                n++;
                if (dropped) begin
                    if (drop_q.size() == 0) chk("drop_unexpected", 1, 0);
                    else chk("drop_cycle", cyc, drop_q.pop_front());
                end
                if (clear_busy) busy_len++;
                else if (busy_len > 0) begin
                    if (busy_q.size() == 0) chk("busy_unexpected", busy_len, 0);
                    else chk("busy_len", busy_len, busy_q.pop_front());
                    busy_len = 0;
                end
                if (vs_prev && !vga_vs) begin
                    if (last_fall >= 0 && frame_q.size() > 0)
                        chk("frame_period", cyc - last_fall, frame_q.pop_front());
                    last_fall = cyc;
                end
                vs_prev = vga_vs;
                if (n >= 2) begin
                    k = (n - 2) / 2;
                    h = k % HT;
                    v = (k / HT) % VT;
                    if (!vga_hs) hs_cnt++;
                    if (vga_blank_n) bl_cnt++;
                    if (!vga_vs) vs_cnt++;
                    if (((n - 2) % 2) == 0 && probe_q.size() > 0 && probe_q[0].h == h &&
                        probe_q[0].v == v && cyc >= probe_q[0].min_cyc) begin
                        chk($sformatf("rgb@%0d,%0d", h, v), int'({vga_r, vga_g, vga_b}), probe_q[0].rgb);
                        chk($sformatf("blank_n@%0d,%0d", h, v), int'(vga_blank_n), probe_q[0].blank);
                        chk($sformatf("hs@%0d,%0d", h, v), int'(vga_hs), probe_q[0].hs);
                        chk($sformatf("vs@%0d,%0d", h, v), int'(vga_vs), probe_q[0].vs);
                        void'(probe_q.pop_front());
                    end
                    if (((n - 2) % 2) == 1 && h == HT - 1) begin
                        if (line_q.size() > 0 && line_q[0].v == v && cyc >= line_q[0].min_cyc) begin
                            chk($sformatf("hs_low_clk@line%0d", v), hs_cnt, line_q[0].hs_lo);
                            chk($sformatf("blank_hi_clk@line%0d", v), bl_cnt, line_q[0].bl_hi);
                            chk($sformatf("vs_low_clk@line%0d", v), vs_cnt, line_q[0].vs_lo);
                            void'(line_q.pop_front());
                        end
                        hs_cnt = 0; bl_cnt = 0; vs_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic drive_plot(input int px, input int py, input int pc, input bit exp_drop);
        plot  = 1'b1;
        X     = 9'(px);
        Y     = 8'(py);
        color = 3'(pc);
        if (exp_drop) drop_q.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic wait_q(input int budget);
        int i = 0;
        while ((probe_q.size() + line_q.size() + drop_q.size() + busy_q.size() + frame_q.size()) > 0
               && i < budget) begin
            @(negedge clk);
            i++;
        end
        if ((probe_q.size() + line_q.size() + drop_q.size() + busy_q.size() + frame_q.size()) > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL timeout: pending probe=%0d line=%0d drop=%0d busy=%0d frame=%0d, expected all 0",
                     probe_q.size(), line_q.size(), drop_q.size(), busy_q.size(), frame_q.size());
            probe_q.delete(); line_q.delete(); drop_q.delete(); busy_q.delete(); frame_q.delete();
        end
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int mc;
        reset = 1'b1; plot = 1'b0; X = '0; Y = '0; color = '0; clear_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // clear, then a single plot at (5,3) color 101
        clear_req = 1'b1;
        busy_q.push_back(FB_W * FB_H);
        @(negedge clk);
        clear_req = 1'b0;
        repeat (FB_W * FB_H + 5) @(negedge clk);
        drive_plot(5, 3, 5, 1'b0);
        plot = 1'b0;
        mc = cyc + 5;
        push_probe(10, 5, 0, mc);
        push_probe(9, 6, 0, mc);
        push_probe(10, 6, 5, mc);
        push_probe(11, 6, 5, mc);
        push_probe(12, 6, 0, mc);
        push_probe(10, 7, 5, mc);
        push_probe(11, 7, 5, mc);
        push_probe(10, 8, 0, mc);

        // out-of-range plots, then the bottom-right corner in white
        drive_plot(16, 0, 1, 1'b1);
        drive_plot(0, 12, 2, 1'b1);
        drive_plot(15, 11, 7, 1'b0);
        plot = 1'b0;
        mc = cyc + 5;
        push_probe(0, 0, 0, mc);
        push_probe(0, 2, 0, mc);
        push_probe(28, 22, 0, mc);
        push_probe(30, 22, 7, mc);
        push_probe(31, 22, 7, mc);
        push_probe(30, 23, 7, mc);
        push_probe(31, 23, 7, mc);
        push_probe(32, 23, 0, mc);
        push_probe(36, 23, 0, mc);
        push_probe(0, 26, 0, mc);
        wait_q(4 * FRAME_CLK);

        // clear with plots in flight, a plot alongside clear_req, one during the sweep,
        // and a second clear_req mid-sweep
        drive_plot(1, 1, 6, 1'b0);
        drive_plot(2, 1, 6, 1'b0);
        clear_req = 1'b1;
        busy_q.push_back(FB_W * FB_H);
        drive_plot(2, 2, 7, 1'b1);
        clear_req = 1'b0;
        plot = 1'b0;
        repeat (20) @(negedge clk);
        drive_plot(3, 3, 7, 1'b1);
        plot = 1'b0;
        repeat (20) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (FB_W * FB_H) @(negedge clk);
        mc = cyc + 2;
        push_probe(2, 2, 0, mc);
        push_probe(4, 2, 0, mc);
        push_probe(4, 4, 0, mc);
        push_probe(6, 6, 0, mc);
        push_probe(10, 6, 0, mc);
        push_probe(30, 22, 0, mc);
        wait_q(4 * FRAME_CLK);

        // free-running line and frame timing
        mc = cyc;
        push_line(0, mc, 16, 64, 0);
        push_line(5, mc, 16, 64, 0);
        push_line(23, mc, 16, 64, 0);
        push_line(24, mc, 16, 0, 0);
        push_line(26, mc, 16, 0, 96);
        push_line(27, mc, 16, 0, 96);
        push_line(29, mc, 16, 0, 0);
        frame_q.push_back(FRAME_CLK);
        wait_q(5 * FRAME_CLK);

        // reset mid-sweep and mid-line, then 100 back-to-back plots
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (57) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) drive_plot(i % 16, i / 16, (i % 7) + 1, 1'b0);
        plot = 1'b0;
        mc = cyc + 5;
        for (int i = 0; i < 100; i++) push_probe(2 * (i % 16), 2 * (i / 16), (i % 7) + 1, mc);
        wait_q(4 * FRAME_CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
